hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 85 ++++++++
 tb/tb_hazard_scoreboard.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: one pending-write counter per architectural
// register, used to stall issue on RAW hazards and on per-register
// outstanding-write capacity.
module hazard_scoreboard #(
    parameter int MAX_PEND = 3,
    parameter int CNT_W    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rs1,
    input  logic [4:0]  issue_rs2,
    input  logic        issue_use_rs1,
    input  logic        issue_use_rs2,
    input  logic [4:0]  issue_rd,
    input  logic        issue_regwrite,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    output logic        stall,
    output logic        issue_fire,
    output logic [31:0] busy_vec,
    output logic        wb_err
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PEND);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    // Entry 0 is never written, so x0 always reads as not pending.
    logic [CNT_W-1:0] cnt     [32];
    logic [CNT_W-1:0] cnt_nxt [32];

    logic haz_rs1;
    logic haz_rs2;
    logic haz_cap;
    logic inc_en;
    logic wb_hit;
    logic dec_en;
    logic wb_zero;

    // Hazard detection from registered counters only; a same-cycle
    // writeback cannot release a stall until the following cycle.
    always_comb begin
        haz_rs1    = issue_use_rs1 && (cnt[issue_rs1] != '0);
        haz_rs2    = issue_use_rs2 && (cnt[issue_rs2] != '0);
        haz_cap    = issue_regwrite && (issue_rd != '0) && (cnt[issue_rd] == MAX_CNT);
        stall      = issue_valid && (haz_rs1 || haz_rs2 || haz_cap);
        issue_fire = issue_valid && !stall;
    end

    // Next counter values: increment on accepted issue, decrement on
    // writeback to a pending register; both on one register cancel.
    always_comb begin
        inc_en  = issue_fire && issue_regwrite && (issue_rd != '0);
        wb_hit  = wb_valid && (wb_rd != '0);
        dec_en  = wb_hit && (cnt[wb_rd] != '0);
        wb_zero = wb_hit && (cnt[wb_rd] == '0);
        for (int unsigned i = 0; i < 32; i++) begin
            cnt_nxt[i] = cnt[i];
            if (i != 0) begin
                if (inc_en && (issue_rd == 5'(i)) && !(dec_en && (wb_rd == 5'(i))))
                    cnt_nxt[i] = cnt[i] + ONE;
                else if (dec_en && (wb_rd == 5'(i)) && !(inc_en && (issue_rd == 5'(i))))
                    cnt_nxt[i] = cnt[i] - ONE;
            end
        end
    end

    // Counter, busy vector and sticky error state; reset overrides all traffic.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 32; i++) begin
                cnt[i] <= '0;
            end
            busy_vec <= '0;
            wb_err   <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < 32; i++) begin
                cnt[i]      <= cnt_nxt[i];
                busy_vec[i] <= (cnt_nxt[i] != '0);
            end
            wb_err <= wb_err | wb_zero;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: a stimulus process drives
// directed and random traffic and pushes expectations from an integer
// reference model; a monitor process pops and compares on the falling edge.
module tb_hazard_scoreboard;

    localparam int MAX_PEND = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic        issue_use_rs1;
    logic        issue_use_rs2;
    logic [4:0]  issue_rd;
    logic        issue_regwrite;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        stall;
    logic        issue_fire;
    logic [31:0] busy_vec;
    logic        wb_err;

    hazard_scoreboard #(.MAX_PEND(MAX_PEND), .CNT_W(2)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
        .issue_rd(issue_rd), .issue_regwrite(issue_regwrite),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .stall(stall), .issue_fire(issue_fire), .busy_vec(busy_vec), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic stall; logic fire; } comb_t;
    typedef struct { logic [31:0] busy; logic err; } state_t;
    comb_t  q_comb  [$];
    state_t q_state [$];

    int passed = 0;
    int total  = 0;

    // Reference model: plain integer pending counts per register.
    int   m_cnt [32];
    logic m_err;

    // Inputs applied in the previous cycle, consumed at the next edge.
    logic       p_rst, p_fire, p_rw, p_wv;
    logic [4:0] p_rd, p_wrd;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s got=%h expected=%h", name, act, exp);
        else passed++;
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] b = '0;
        for (int i = 1; i < 32; i++) b[i] = (m_cnt[i] > 0);
        return b;
    endfunction

    function automatic logic m_stall(logic iv, logic [4:0] rs1, logic [4:0] rs2,
                                     logic u1, logic u2, logic [4:0] rd, logic rw);
        logic h1, h2, hc;
        h1 = u1 && (m_cnt[rs1] > 0);
        h2 = u2 && (m_cnt[rs2] > 0);
        hc = rw && (rd != 0) && (m_cnt[rd] == MAX_PEND);
        return iv && (h1 || h2 || hc);
    endfunction

    // One cycle: retire last cycle's inputs into the model at the edge,
    // then apply new inputs and queue the expected combinational response.
    task automatic step(input logic iv, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic wv, input logic [4:0] wrd,
                        input logic rst);
        comb_t  c;
        state_t s;
        @(posedge clk);
        #1;
        if (p_rst) begin
            for (int i = 0; i < 32; i++) m_cnt[i] = 0;
            m_err = 1'b0;
        end else begin
            if (p_wv && p_wrd != 0) begin
                if (m_cnt[p_wrd] > 0) m_cnt[p_wrd] = m_cnt[p_wrd] - 1;
                else m_err = 1'b1;
            end
            if (p_fire && p_rw && p_rd != 0) m_cnt[p_rd] = m_cnt[p_rd] + 1;
        end
        s.busy = m_busy();
        s.err  = m_err;
        q_state.push_back(s);

        reset = rst; issue_valid = iv; issue_rs1 = rs1; issue_rs2 = rs2;
        issue_use_rs1 = u1; issue_use_rs2 = u2; issue_rd = rd; issue_regwrite = rw;
        wb_valid = wv; wb_rd = wrd;
        c.stall = m_stall(iv, rs1, rs2, u1, u2, rd, rw);
        c.fire  = iv && !c.stall;
        q_comb.push_back(c);
        p_rst = rst; p_fire = c.fire; p_rw = rw; p_rd = rd; p_wv = wv; p_wrd = wrd;
    endtask

    task automatic idle(input logic rst);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, rst);
    endtask

    // Monitor: outputs are presented every cycle; compare whatever is queued.
    initial begin
        comb_t  c;
        state_t s;
        forever begin
            @(negedge clk);
            if (q_state.size() > 0) begin
                s = q_state.pop_front();
                chk("busy_vec", busy_vec, s.busy);
                chk("wb_err", {31'd0, wb_err}, {31'd0, s.err});
            end
            if (q_comb.size() > 0) begin
                c = q_comb.pop_front();
                chk("stall", {31'd0, stall}, {31'd0, c.stall});
                chk("issue_fire", {31'd0, issue_fire}, {31'd0, c.fire});
            end
        end
    end

    initial begin
        logic       iv, u1, u2, rw, wv, rst;
        logic [4:0] rs1, rs2, rd, wrd;
        reset = 1'b1; issue_valid = 1'b0; issue_rs1 = '0; issue_rs2 = '0;
        issue_use_rs1 = 1'b0; issue_use_rs2 = 1'b0; issue_rd = '0; issue_regwrite = 1'b0;
        wb_valid = 1'b0; wb_rd = '0;
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_err = 1'b0;
        repeat (2) @(posedge clk);
        p_rst = 1'b1; p_fire = 1'b0; p_rw = 1'b0; p_rd = '0; p_wv = 1'b0; p_wrd = '0;

        // First cycle after reset: issue with sources must not stall.
        step(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);

        // RAW on x5, released the cycle after the writeback.
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0);
        step(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        step(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        step(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
        step(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);

        // Capacity on x7: three in flight, fourth waits for one writeback.
        repeat (3) step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0);
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0);
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0);
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0);
        idle(1'b0);

        // Same-cycle issue and writeback on x9 with one pending.
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0);
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0);
        // Simultaneous increment and decrement on different registers.
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd10, 1'b1, 1'b1, 5'd9, 1'b0);
        idle(1'b0);

        // x0 as destination and sources is ignored.
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0);
        step(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);

        // Spurious writeback to x12 sets the sticky error.
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd12, 1'b0);
        repeat (3) idle(1'b0);

        // Reset with issue pending discards all counts; late writeback errors.
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0);
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 5'd0, 1'b0);
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b1);
        idle(1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0);
        idle(1'b0);
        idle(1'b1);

        // Random traffic over a small register window to provoke hazards.
        for (int n = 0; n < 600; n++) begin
            iv  = ($urandom_range(0, 3) != 0);
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            u1  = $urandom_range(0, 1) == 1;
            u2  = $urandom_range(0, 1) == 1;
            rd  = 5'($urandom_range(0, 7));
            rw  = $urandom_range(0, 3) != 0;
            wv  = $urandom_range(0, 2) == 0;
            wrd = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 15) != 0) begin
                for (int k = 0; k < 8; k++) begin
                    if (m_cnt[wrd] > 0) break;
                    wrd = 5'((int'(wrd) + 1) % 8);
                end
            end
            // Keep a writeback to an empty register off the register being issued.
            if (wv && wrd == rd && m_cnt[wrd] == 0) wv = 1'b0;
            rst = ($urandom_range(0, 149) == 0);
            step(iv, rs1, rs2, u1, u2, rd, rw, wv, wrd, rst);
        end
        idle(1'b0);
        idle(1'b0);

        @(negedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
